// File: rtl/io_write_drain_arbiter_if.sv
// rtl/io_write_drain_arbiter_if.sv - shared downstream valid/ready channel of the I/O write drain
// master drives the word, slave accepts it with out_ready.
interface io_write_drain_arbiter_if #(
  parameter int WORD_WIDTH    = 36,
  parameter int PORT_ID_WIDTH = 2
);
  logic                     out_valid;
  logic                     out_ready;
  logic [WORD_WIDTH-1:0]    out_data;
  logic [PORT_ID_WIDTH-1:0] out_port_id;

  modport master (
    output out_valid,
    output out_data,
    output out_port_id,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_port_id,
    output out_ready
  );
endinterface

// File: rtl/io_write_drain_arbiter.sv
// rtl/io_write_drain_arbiter.sv - round-robin drain of per-port I/O write holding registers onto one channel
// Optional: define IO_DRAIN_OVERFLOW_DETECT_EN for sticky per-port write-while-full flags.
module io_write_drain_arbiter #(
  parameter int WORD_WIDTH    = 36,
  parameter int PORT_COUNT    = 4,
  parameter int PORT_ID_WIDTH = 2
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [PORT_COUNT-1:0]            port_wren,
  input  logic [PORT_COUNT*WORD_WIDTH-1:0] port_data,
  output logic [PORT_COUNT-1:0]            EmptyFull,
  output logic [PORT_COUNT-1:0]            overflow,
  io_write_drain_arbiter_if.master         out_if
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [PORT_COUNT-1:0]    r_full;
  logic [WORD_WIDTH-1:0]    r_hold [PORT_COUNT];
  logic [PORT_ID_WIDTH-1:0] r_last_grant;
  logic [PORT_ID_WIDTH-1:0] r_out_port_id;
  logic [WORD_WIDTH-1:0]    r_out_data;
  logic [PORT_ID_WIDTH-1:0] w_winner;
  logic                     w_found;
  logic                     w_any_full;
  logic                     w_grant_slot;
  logic                     w_do_grant;
  logic                     w_out_valid;
  logic [PORT_COUNT-1:0]    w_granted;
  logic [PORT_COUNT-1:0]    w_capture;

  assign w_any_full   = |r_full;
  // The output register may take a new word when empty or when its current word is accepted.
  assign w_grant_slot = (r_state == ST_IDLE) || out_if.out_ready;
  assign w_do_grant   = w_grant_slot && w_any_full;

  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    for (int k = 1; k <= PORT_COUNT; k++) begin
      if (!w_found && r_full[(int'(r_last_grant) + k) % PORT_COUNT]) begin
        w_found  = 1'b1;
        w_winner = PORT_ID_WIDTH'((int'(r_last_grant) + k) % PORT_COUNT);
      end
    end
  end

  // A port being granted frees its slot on the same edge, so a concurrent write is captured.
  always_comb begin
    w_granted = '0;
    w_capture = '0;
    for (int i = 0; i < PORT_COUNT; i++) begin
      w_granted[i] = w_do_grant && (w_winner == PORT_ID_WIDTH'(i));
      w_capture[i] = port_wren[i] && (!r_full[i] || w_granted[i]);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_full <= '0;
      for (int i = 0; i < PORT_COUNT; i++) begin
        r_hold[i] <= '0;
      end
    end else begin
      for (int i = 0; i < PORT_COUNT; i++) begin
        if (w_capture[i]) begin
          r_full[i] <= 1'b1;
          r_hold[i] <= port_data[i*WORD_WIDTH +: WORD_WIDTH];
        end else if (w_granted[i]) begin
          r_full[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_data    <= '0;
      r_out_port_id <= '0;
      r_last_grant  <= PORT_ID_WIDTH'(PORT_COUNT - 1);
    end else if (w_do_grant) begin
      r_out_data    <= r_hold[w_winner];
      r_out_port_id <= w_winner;
      r_last_grant  <= w_winner;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_any_full) w_state_next = ST_HOLD;
      ST_HOLD: if (out_if.out_ready && !w_any_full) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_out_valid = (r_state == ST_HOLD);
  end

  assign out_if.out_valid   = w_out_valid;
  assign out_if.out_data    = r_out_data;
  assign out_if.out_port_id = r_out_port_id;
  assign EmptyFull          = r_full;

`ifdef IO_DRAIN_OVERFLOW_DETECT_EN
  logic [PORT_COUNT-1:0] r_overflow;
  logic [PORT_COUNT-1:0] w_drop;

  assign w_drop = port_wren & r_full & ~w_granted;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= '0;
    end else begin
      r_overflow <= r_overflow | w_drop;
    end
  end

  assign overflow = r_overflow;
`else
  assign overflow = '0;
`endif

endmodule

// File: tb/tb_io_write_drain_arbiter.sv
// tb/tb_io_write_drain_arbiter.sv - scoreboard bench for io_write_drain_arbiter
module tb_io_write_drain_arbiter;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [3:0]   port_wren;
  logic [143:0] port_data;
  logic [3:0]   EmptyFull;
  logic [3:0]   overflow;

  io_write_drain_arbiter_if #(.WORD_WIDTH(36), .PORT_ID_WIDTH(2)) out_if ();

  io_write_drain_arbiter #(
    .WORD_WIDTH   (36),
    .PORT_COUNT   (4),
    .PORT_ID_WIDTH(2)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .port_wren(port_wren),
    .port_data(port_data),
    .EmptyFull(EmptyFull),
    .overflow (overflow),
    .out_if   (out_if)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0]  id;
    logic [35:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input int p, input logic [35:0] d);
    port_wren[p]          = 1'b1;
    port_data[p*36 +: 36] = d;
    sb_q.push_back({2'(p), d});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sb_q.delete();
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb_q.size() != 0 || out_if.out_valid) && n < 50) begin
      step();
      n++;
    end
    check("drain_in_budget", 64'(n < 50), 64'd1);
  endtask

  always @(negedge clock) begin
    if (reset_n && out_if.out_valid && out_if.out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_nonempty", 64'(sb_q.size()), 64'd1);
      end else begin
        sb_e = sb_q.pop_front();
        check("sb_port", 64'(out_if.out_port_id), 64'(sb_e.id));
        check("sb_data", 64'(out_if.out_data), 64'(sb_e.data));
      end
    end
  end

  initial begin
    reset_n          = 1'b0;
    port_wren        = '0;
    port_data        = '0;
    out_if.out_ready = 1'b0;
    #12;
    check("rst_emptyfull", 64'(EmptyFull), 64'd0);
    check("rst_valid", 64'(out_if.out_valid), 64'd0);
    check("rst_data", 64'(out_if.out_data), 64'd0);
    check("rst_port_id", 64'(out_if.out_port_id), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    step();
    reset_n = 1'b1;

    // single write on port 2
    out_if.out_ready = 1'b1;
    put(2, 36'h0000000AB);
    step();
    port_wren = '0;
    check("single_full", 64'(EmptyFull), 64'h4);
    check("single_not_yet", 64'(out_if.out_valid), 64'd0);
    step();
    check("single_valid", 64'(out_if.out_valid), 64'd1);
    check("single_id", 64'(out_if.out_port_id), 64'd2);
    check("single_data", 64'(out_if.out_data), 64'hAB);
    check("single_empty", 64'(EmptyFull), 64'd0);
    wait_drain();

    // asynchronous reset with a word in the output stage and another held
    out_if.out_ready = 1'b0;
    port_wren = 4'b1010;
    port_data[1*36 +: 36] = 36'h123;
    port_data[3*36 +: 36] = 36'h321;
    step();
    port_wren = '0;
    step();
    check("mid_valid_before", 64'(out_if.out_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_if.out_valid), 64'd0);
    check("mid_rst_emptyfull", 64'(EmptyFull), 64'd0);
    check("mid_rst_data", 64'(out_if.out_data), 64'd0);
    do_reset();

    // round-robin from reset: ports 0..3 on consecutive cycles
    out_if.out_ready = 1'b1;
    for (int p = 0; p < 4; p++) put(p, 36'(p + 1));
    step();
    port_wren = '0;
    check("rr_all_full", 64'(EmptyFull), 64'hF);
    for (int k = 0; k < 4; k++) begin
      step();
      check("rr_valid", 64'(out_if.out_valid), 64'd1);
      check("rr_id", 64'(out_if.out_port_id), 64'(k));
      check("rr_data", 64'(out_if.out_data), 64'(k + 1));
    end
    step();
    check("rr_idle", 64'(out_if.out_valid), 64'd0);

    // wrap-around: after granting port 2, port 3 precedes port 0
    put(2, 36'h22);
    step();
    port_wren = '0;
    wait_drain();
    put(0, 36'h30);
    put(3, 36'h33);
    sb_q.delete();
    sb_q.push_back({2'd3, 36'h33});
    sb_q.push_back({2'd0, 36'h30});
    step();
    port_wren = '0;
    step();
    check("wrap_first", 64'(out_if.out_port_id), 64'd3);
    step();
    check("wrap_second", 64'(out_if.out_port_id), 64'd0);
    wait_drain();

    // backpressure on port 1
    out_if.out_ready = 1'b0;
    put(1, 36'h1B0);
    step();
    port_wren = '0;
    step();
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 64'(out_if.out_valid), 64'd1);
      check("bp_data", 64'(out_if.out_data), 64'h1B0);
      check("bp_id", 64'(out_if.out_port_id), 64'd1);
      step();
    end
    out_if.out_ready = 1'b1;
    step();
    check("bp_accepted", 64'(out_if.out_valid), 64'd0);

    // write while full on port 3 is dropped
    out_if.out_ready = 1'b0;
    put(3, 36'hA3);
    step();
    port_wren = '0;
    step();
    put(3, 36'hB3);
    step();
    port_wren = 4'b1000;
    port_data[3*36 +: 36] = 36'h5;
    step();
    port_wren = '0;
    check("wwf_full", 64'(EmptyFull), 64'h8);
    check("wwf_out_data", 64'(out_if.out_data), 64'hA3);
`ifdef IO_DRAIN_OVERFLOW_DETECT_EN
    check("wwf_overflow", 64'(overflow), 64'h8);
`else
    check("wwf_overflow", 64'(overflow), 64'h0);
`endif
    out_if.out_ready = 1'b1;
    wait_drain();

    // grant and write to port 0 on the same edge
    put(0, 36'h6);
    step();
    put(0, 36'h7);
    step();
    port_wren = '0;
    check("gw_full_kept", 64'(EmptyFull[0]), 64'd1);
    check("gw_first", 64'(out_if.out_data), 64'h6);
    step();
    check("gw_second", 64'(out_if.out_data), 64'h7);
    check("gw_no_overflow", 64'(overflow[0]), 64'd0);
    wait_drain();

    check("sb_empty_end", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
